// File: rtl/pattern_gen_64bit_pkg.sv
// Shared constants and state encoding for the 64-bit lane-pair pattern generator and checker.
package pattern_pkg;

    localparam logic [63:0] PAT_SEED   = 64'h0000_0002_0000_0001;
    localparam logic [63:0] PAT_INC    = 64'h0000_0002_0000_0002;
    localparam logic [63:0] PAT_RESYNC = 64'h0000_0001_0000_0000;
    localparam int unsigned PAT_CNT_W  = 32'd32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } pat_state_e;

    // A programmed length of zero still produces one-word packets.
    function automatic logic [15:0] eff_len(input logic [15:0] len);
        return (len == 16'd0) ? 16'd1 : len;
    endfunction

endpackage

// File: rtl/pattern_gen_64bit_sat_cnt.sv
// Width-parameterised counter that sticks at all-ones instead of wrapping.
module sat_cnt #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             t_clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: step when enabled unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge t_clk) begin
        if (rst) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pattern_gen_64bit.sv
// Packetised incrementing-pattern source with gap control, restart and single-shot error injection.
module pattern_gen_64bit
    import pattern_pkg::*;
#(
    parameter logic [63:0] SEED  = PAT_SEED,
    parameter logic [63:0] INC   = PAT_INC,
    parameter int unsigned CNT_W = PAT_CNT_W
) (
    input  logic             t_clk,
    input  logic             rst,
    input  logic             gen_en,
    input  logic             restart,
    input  logic             inj_err,
    input  logic [15:0]      cfg_pkt_len,
    input  logic [7:0]       cfg_gap,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [63:0]      tx_data,
    output logic             tx_sof,
    output logic             tx_eof,
    output logic             gen_busy,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] inj_cnt
);

    pat_state_e  state_q, state_d;
    logic [63:0] seq_q, seq_d, data_q, data_d, seq_inc_s;
    logic [15:0] len_q, len_d, beat_q, beat_d, len_cfg_s;
    logic [7:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic        valid_q, valid_d, sof_q, sof_d, eof_q, eof_d, busy_q, busy_d;
    logic        pend_q, pend_d, corrupt_q, corrupt_d, rst_pend_q, rst_pend_d;
    logic        xfer_s, hold_s, restart_s, start_pkt_s;

    assign xfer_s    = valid_q & tx_ready;
    assign hold_s    = valid_q & ~tx_ready;
    assign restart_s = rst_pend_q | restart;
    assign seq_inc_s = seq_q + INC;
    assign len_cfg_s = eff_len(cfg_pkt_len);

    // Sequencing FSM, packet framing and the injection/restart bookkeeping.
    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        beat_d      = beat_q;
        len_d       = len_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        rst_pend_d  = restart_s;
        valid_d     = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        start_pkt_s = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                // Between packets a restart takes effect at once.
                if (restart_s) begin
                    seq_d  = SEED;
                    beat_d = 16'd0;
                end else begin
                    seq_d  = seq_q;
                end
                rst_pend_d = 1'b0;
                if ((state_q == GAP) && (gap_cnt_q != (gap_q - 8'd1))) begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end else if (gen_en) begin
                    start_pkt_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (xfer_s && eof_q) begin
                    seq_d      = restart_s ? SEED : seq_inc_s;
                    beat_d     = 16'd0;
                    rst_pend_d = 1'b0;
                    if (gap_q != 8'd0) begin
                        state_d   = GAP;
                        gap_cnt_d = 8'd0;
                    end else if (gen_en) begin
                        start_pkt_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer_s) begin
                    seq_d   = seq_inc_s;
                    beat_d  = beat_q + 16'd1;
                    valid_d = 1'b1;
                    eof_d   = ((beat_q + 16'd1) == (len_q - 16'd1));
                end else begin
                    valid_d = 1'b1;
                    sof_d   = sof_q;
                    eof_d   = eof_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_pkt_s) begin
            state_d = SEND;
            len_d   = len_cfg_s;
            gap_d   = cfg_gap;
            beat_d  = 16'd0;
            valid_d = 1'b1;
            sof_d   = 1'b1;
            eof_d   = (len_cfg_s == 16'd1);
        end else begin
            len_d = len_d;
        end

        // Pending clears only when a corrupted word actually leaves.
        if (xfer_s && corrupt_q) begin
            pend_d = 1'b0;
        end else if (inj_err) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        if (hold_s) begin
            data_d    = data_q;
            corrupt_d = corrupt_q;
        end else begin
            corrupt_d = pend_d;
            data_d    = seq_d ^ {63'd0, pend_d};
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered output stage.
    always_ff @(posedge t_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            seq_q      <= SEED;
            data_q     <= SEED;
            beat_q     <= 16'd0;
            len_q      <= 16'd1;
            gap_q      <= 8'd0;
            gap_cnt_q  <= 8'd0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            busy_q     <= 1'b0;
            pend_q     <= 1'b0;
            corrupt_q  <= 1'b0;
            rst_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            data_q     <= data_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            corrupt_q  <= corrupt_d;
            rst_pend_q <= rst_pend_d;
        end
    end

    sat_cnt #(.WIDTH(CNT_W)) u_word_cnt (
        .t_clk (t_clk),
        .rst   (rst),
        .inc_i (xfer_s),
        .cnt_o (word_cnt)
    );

    sat_cnt #(.WIDTH(CNT_W)) u_pkt_cnt (
        .t_clk (t_clk),
        .rst   (rst),
        .inc_i (xfer_s & eof_q),
        .cnt_o (pkt_cnt)
    );

    sat_cnt #(.WIDTH(CNT_W)) u_inj_cnt (
        .t_clk (t_clk),
        .rst   (rst),
        .inc_i (xfer_s & corrupt_q),
        .cnt_o (inj_cnt)
    );

    assign tx_valid = valid_q;
    assign tx_data  = data_q;
    assign tx_sof   = sof_q;
    assign tx_eof   = eof_q;
    assign gen_busy = busy_q;

endmodule

// File: tb/tb_pattern_gen_64bit.sv
// Table-driven bench for pattern_gen_64bit with an expected-word scoreboard.
module tb_pattern_gen_64bit;

    localparam logic [63:0] SEED = 64'h0000_0002_0000_0001;
    localparam logic [63:0] INC  = 64'h0000_0002_0000_0002;

    logic        t_clk, rst, gen_en, restart, inj_err, tx_ready;
    logic [15:0] cfg_pkt_len;
    logic [7:0]  cfg_gap;
    logic        tx_valid, tx_sof, tx_eof, gen_busy;
    logic [63:0] tx_data;
    logic [31:0] word_cnt, pkt_cnt, inj_cnt;
    logic        sat_rst, sat_inc;
    logic [3:0]  sat_val;

    pattern_gen_64bit dut (
        .t_clk(t_clk), .rst(rst), .gen_en(gen_en), .restart(restart), .inj_err(inj_err),
        .cfg_pkt_len(cfg_pkt_len), .cfg_gap(cfg_gap), .tx_ready(tx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_sof(tx_sof), .tx_eof(tx_eof),
        .gen_busy(gen_busy), .word_cnt(word_cnt), .pkt_cnt(pkt_cnt), .inj_cnt(inj_cnt)
    );

    sat_cnt #(.WIDTH(4)) u_sat (.t_clk(t_clk), .rst(sat_rst), .inc_i(sat_inc), .cnt_o(sat_val));

    typedef struct {
        logic [63:0] d;
        logic        sof;
        logic        eof;
    } exp_t;

    typedef struct {
        int len; int gap; int npkts; int stall_at; int inj_at; int rst_at;
        int exp_words; int exp_pkts; int exp_inj;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];

    int checks = 0, failures = 0;
    int cyc = 0, xfer_n, sof_n, stop_after, inj_at, rst_at, start_cyc, last_eof, cur_gap;
    bit have_eof;

    initial begin
        t_clk = 1'b0;
        forever #5 t_clk = ~t_clk;
    end

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge t_clk);
        cyc++;
        inj_err = 1'b0;
        restart = 1'b0;
        if (tx_valid && tx_ready) begin
            xfer_n++;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {tx_data, tx_sof, tx_eof}, 66'd0);
            end else begin
                e = exp_q.pop_front();
                chk("word", {tx_data, tx_sof, tx_eof}, {e.d, e.sof, e.eof});
            end
            if (tx_sof) begin
                sof_n++;
                if (sof_n == 1) chk("start_latency", 66'(cyc), 66'(start_cyc + 2));
                else if (have_eof) chk("gap_len", 66'(cyc), 66'(last_eof + cur_gap + 1));
                if (sof_n == stop_after) gen_en = 1'b0;
            end
            if (tx_eof) begin
                have_eof = 1'b1;
                last_eof = cyc;
            end
            if (xfer_n == inj_at) inj_err = 1'b1;
            if (xfer_n == rst_at) restart = 1'b1;
        end
        @(posedge t_clk);
        #1;
    endtask

    task automatic do_reset();
        gen_en = 1'b0; restart = 1'b0; inj_err = 1'b0; tx_ready = 1'b1;
        rst = 1'b1;
        repeat (2) begin @(posedge t_clk); #1; end
        rst = 1'b0;
    endtask

    // Reference stream: pattern index k restarts at zero after a packet that saw restart.
    task automatic push_expected(input vec_t v);
        int L, k, t;
        bit rp;
        exp_t e;
        L = (v.len == 0) ? 1 : v.len;
        k = 0; t = 0; rp = 1'b0;
        for (int p = 0; p < v.npkts; p++) begin
            for (int b = 0; b < L; b++) begin
                t++;
                e.d = SEED + 64'(k) * INC;
                if (v.inj_at > 0 && t == v.inj_at + 1) e.d = e.d ^ 64'h1;
                e.sof = (b == 0);
                e.eof = (b == L - 1);
                exp_q.push_back(e);
                k++;
                if (t == v.rst_at) rp = 1'b1;
            end
            if (rp) begin k = 0; rp = 1'b0; end
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [63:0] s_data;
        logic s_sof, s_eof;
        logic [31:0] s_wc;
        int budget;
        bit stalled;
        do_reset();
        exp_q.delete();
        cfg_pkt_len = 16'(v.len);
        cfg_gap = 8'(v.gap);
        cur_gap = v.gap;
        push_expected(v);
        xfer_n = 0; sof_n = 0; have_eof = 1'b0; last_eof = 0; stalled = 1'b0;
        stop_after = v.npkts; inj_at = v.inj_at; rst_at = v.rst_at;
        gen_en = 1'b1;
        start_cyc = cyc;
        budget = 0;
        while (exp_q.size() > 0 && budget < 400) begin
            cycle();
            budget++;
            if (v.stall_at > 0 && xfer_n == v.stall_at && !stalled) begin
                stalled = 1'b1;
                tx_ready = 1'b0;
                @(negedge t_clk);
                s_data = tx_data; s_sof = tx_sof; s_eof = tx_eof; s_wc = word_cnt;
                repeat (5) begin
                    @(posedge t_clk); #1;
                    chk("stall_hold", {tx_valid, tx_data, tx_sof},
                        {1'b1, s_data, s_sof});
                    chk("stall_eof_cnt", {s_wc, 33'd0, tx_eof}, {word_cnt, 33'd0, s_eof});
                end
                tx_ready = 1'b1;
            end
        end
        chk("drain", 66'(exp_q.size()), 66'd0);
        repeat (v.gap + 3) cycle();
        chk("word_cnt", 66'(word_cnt), 66'(v.exp_words));
        chk("pkt_cnt", 66'(pkt_cnt), 66'(v.exp_pkts));
        chk("inj_cnt", 66'(inj_cnt), 66'(v.exp_inj));
        chk("idle_after", {gen_busy, tx_valid}, 66'd0);
    endtask

    initial begin
        rst = 1'b1; gen_en = 1'b0; restart = 1'b0; inj_err = 1'b0; tx_ready = 1'b1;
        cfg_pkt_len = 16'd4; cfg_gap = 8'd2;
        sat_rst = 1'b1; sat_inc = 1'b0;

        //          len gap n  stall inj rst words pkts inj
        vecs[0] = '{4,  2,  2, 0,    0,  0,  8,    2,   0};
        vecs[1] = '{4,  2,  1, 2,    0,  0,  4,    1,   0};
        vecs[2] = '{4,  2,  1, 0,    2,  0,  4,    1,   1};
        vecs[3] = '{8,  0,  1, 0,    0,  0,  8,    1,   0};
        vecs[4] = '{4,  0,  2, 0,    0,  2,  8,    2,   0};
        vecs[5] = '{0,  0,  3, 0,    0,  0,  3,    3,   0};
        vecs[6] = '{1,  1,  3, 0,    0,  1,  3,    3,   0};
        vecs[7] = '{3,  3,  2, 0,    3,  0,  6,    2,   1};

        do_reset();
        chk("reset_ctrl", {tx_valid, tx_sof, tx_eof, gen_busy}, 66'd0);
        chk("reset_data", 66'(tx_data), 66'(SEED));
        chk("reset_cnts", {word_cnt, pkt_cnt, inj_cnt[1:0]}, 66'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of a packet abandons it without eof.
        do_reset();
        cfg_pkt_len = 16'd8; cfg_gap = 8'd0;
        gen_en = 1'b1;
        repeat (4) begin @(posedge t_clk); #1; end
        chk("midrst_busy", 66'(gen_busy), 66'd1);
        rst = 1'b1;
        @(posedge t_clk); #1;
        chk("midrst_ctrl", {tx_valid, tx_sof, tx_eof, gen_busy}, 66'd0);
        chk("midrst_data", 66'(tx_data), 66'(SEED));
        chk("midrst_cnt", 66'(word_cnt), 66'd0);
        rst = 1'b0; gen_en = 1'b0;

        // Saturation on a narrow counter instance.
        @(posedge t_clk); #1;
        sat_rst = 1'b0;
        sat_inc = 1'b1;
        repeat (5) begin @(posedge t_clk); #1; end
        chk("sat_mid", 66'(sat_val), 66'd5);
        repeat (15) begin @(posedge t_clk); #1; end
        chk("sat_top", 66'(sat_val), 66'd15);
        repeat (3) begin @(posedge t_clk); #1; end
        chk("sat_hold", 66'(sat_val), 66'd15);
        sat_inc = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
